// File: rtl/lfsr_pkg.sv
// Shared types for the LFSR sequencer: opcode set, FSM states, instruction field widths.
package lfsr_pkg;
  localparam int INSTR_W  = 14;
  localparam int OPC_W    = 6;
  localparam int FUNCT_W  = 7;
  localparam int IMM_W    = 8;
  localparam int RUNCNT_W = 5;

  typedef enum logic [OPC_W-1:0] {
    CFG_TAP   = 6'h01,
    INIT_L    = 6'h02,
    RUN_L     = 6'h03,
    STORE     = 6'h04,
    LOAD      = 6'h05,
    INIT_ADDR = 6'h06,
    ADD_ADDR  = 6'h07,
    HALT      = 6'h3F
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RUN,
    ST_HALT
  } state_t;
endpackage

// File: rtl/lfsr_decode.sv
// Combinational instruction decode: opcode class, 8-bit immediate and a legality flag.
module lfsr_decode
  import lfsr_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output opcode_t            op,
  output logic [IMM_W-1:0]   imm8,
  output logic               legal
);
  always_comb begin
    imm8  = instr[IMM_W-1:0];
    op    = CFG_TAP;
    legal = 1'b1;
    case (instr[INSTR_W-1:IMM_W])
      CFG_TAP:   op = CFG_TAP;
      INIT_L:    op = INIT_L;
      RUN_L:     op = RUN_L;
      STORE:     op = STORE;
      LOAD:      op = LOAD;
      INIT_ADDR: op = INIT_ADDR;
      ADD_ADDR:  op = ADD_ADDR;
      HALT:      op = HALT;
      default:   legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Micro-sequencer that fetches 14-bit instructions and drives LFSR/data-memory strobes.
module lfsr_seq_ctrl
  import lfsr_pkg::*;
#(
  parameter int IMEM_AW = 8,
  parameter int DMEM_AW = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [13:0]        imem_data,
  output logic [6:0]         tap,
  output logic               lfsr_load,
  output logic [7:0]         lfsr_seed,
  output logic               lfsr_step,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic               dmem_we,
  output logic               dmem_re,
  output logic               busy,
  output logic               halted,
  output logic               illegal,
  output logic [4:0]         run_count
);
  localparam logic [IMEM_AW-1:0] PC_ONE = 1;

  state_t                state_q, state_d;
  logic [IMEM_AW-1:0]    pc_q, pc_d;
  logic [FUNCT_W-1:0]    tap_q, tap_d;
  logic [DMEM_AW-1:0]    addr_q, addr_d;
  logic [IMM_W-1:0]      cnt_q, cnt_d;
  logic [RUNCNT_W-1:0]   runs_q, runs_d;
  logic                  illegal_q, illegal_d;

  opcode_t               op;
  logic [IMM_W-1:0]      imm8;
  logic                  legal;

  lfsr_decode u_decode (
    .instr (imem_data),
    .op    (op),
    .imm8  (imm8),
    .legal (legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      tap_q     <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      runs_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      tap_q     <= tap_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      runs_q    <= runs_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tap_d     = tap_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    runs_d    = runs_q;
    illegal_d = illegal_q;
    lfsr_load = 1'b0;
    lfsr_seed = '0;
    lfsr_step = 1'b0;
    dmem_we   = 1'b0;
    dmem_re   = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          pc_d      = '0;
          state_d   = ST_EXEC;
          illegal_d = 1'b0;
        end
      end
      ST_EXEC: begin
        pc_d = pc_q + PC_ONE;
        if (!legal) begin
          illegal_d = 1'b1;
        end else begin
          case (op)
            CFG_TAP: if (!imm8[7]) tap_d = imm8[FUNCT_W-1:0];
            INIT_L: begin
              lfsr_load = 1'b1;
              lfsr_seed = imm8;
            end
            RUN_L: begin
              if (runs_q != 5'd31) runs_d = runs_q + 5'd1;
              lfsr_step = (imm8 != 8'd0);
              // The EXEC cycle supplies the first step; RUN supplies the remaining N-1.
              if (imm8 > 8'd1) begin
                cnt_d   = imm8 - 8'd1;
                state_d = ST_RUN;
                pc_d    = pc_q;
              end
            end
            STORE:     dmem_we = 1'b1;
            LOAD:      dmem_re = 1'b1;
            INIT_ADDR: addr_d  = DMEM_AW'(imm8);
            ADD_ADDR:  addr_d  = addr_q + DMEM_AW'(imm8);
            HALT: begin
              state_d = ST_HALT;
              pc_d    = pc_q;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        lfsr_step = 1'b1;
        cnt_d     = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = ST_EXEC;
          pc_d    = pc_q + PC_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign imem_addr = pc_q;
  assign tap       = tap_q;
  assign dmem_addr = addr_q;
  assign run_count = runs_q;
  assign illegal   = illegal_q;
  assign busy      = (state_q == ST_EXEC) || (state_q == ST_RUN);
  assign halted    = (state_q == ST_HALT);
endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Self-checking bench: an ISA-level interpreter expands each program into an expected per-cycle trace.
module tb_lfsr_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  imem_addr;
  logic [13:0] imem_data;
  logic [6:0]  tap;
  logic        lfsr_load;
  logic [7:0]  lfsr_seed;
  logic        lfsr_step;
  logic [7:0]  dmem_addr;
  logic        dmem_we, dmem_re, busy, halted, illegal;
  logic [4:0]  run_count;

  logic [13:0] imem [256];
  assign imem_data = imem[imem_addr];

  always #5 clk = ~clk;

  lfsr_seq_ctrl #(.IMEM_AW(8), .DMEM_AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_addr(imem_addr), .imem_data(imem_data), .tap(tap),
    .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed), .lfsr_step(lfsr_step),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_re(dmem_re),
    .busy(busy), .halted(halted), .illegal(illegal), .run_count(run_count)
  );

  typedef struct {
    int pc, load, seed, step, we, re, addr, tap, runs, busy, halted, ill;
  } rec_t;

  rec_t exp_q[$];
  rec_t e;
  int checks = 0;
  int failures = 0;
  int m_tap = 0, m_addr = 0, m_runs = 0, m_ill = 0;
  int step_cnt = 0, we_cnt = 0, busy_cnt = 0;

  function automatic void chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endfunction

  function automatic int sat(input int v);
    return (v > 31) ? 31 : v;
  endfunction

  function automatic rec_t base(input int pc);
    rec_t r;
    r.pc = pc; r.load = 0; r.seed = 0; r.step = 0; r.we = 0; r.re = 0;
    r.addr = m_addr; r.tap = m_tap; r.runs = m_runs;
    r.busy = 1; r.halted = 0; r.ill = m_ill;
    return r;
  endfunction

  task automatic push_halt(input int pc);
    rec_t r;
    r = base(pc);
    exp_q.push_back(r);
    r.busy = 0; r.halted = 1;
    repeat (2) exp_q.push_back(r);
  endtask

  // Expand the program in imem into the cycle-by-cycle outputs it must produce.
  task automatic expand(input int max_instr);
    int pc, op, imm;
    rec_t r;
    pc = 0;
    m_ill = 0;
    for (int k = 0; k < max_instr; k++) begin
      op  = int'(imem[pc[7:0]][13:8]);
      imm = int'(imem[pc[7:0]][7:0]);
      r = base(pc);
      if (op == 63) begin
        push_halt(pc);
        return;
      end
      pc = (pc + 1) % 256;
      case (op)
        1: begin exp_q.push_back(r); if (imm < 128) m_tap = imm; end
        2: begin r.load = 1; r.seed = imm; exp_q.push_back(r); end
        3: begin
          if (imm == 0) exp_q.push_back(r);
          for (int s = 0; s < imm; s++) begin
            r.step = 1;
            r.runs = (s == 0) ? m_runs : sat(m_runs + 1);
            exp_q.push_back(r);
          end
          m_runs = sat(m_runs + 1);
        end
        4: begin r.we = 1; exp_q.push_back(r); end
        5: begin r.re = 1; exp_q.push_back(r); end
        6: begin exp_q.push_back(r); m_addr = imm; end
        7: begin exp_q.push_back(r); m_addr = (m_addr + imm) % 256; end
        default: begin exp_q.push_back(r); m_ill = 1; end
      endcase
    end
  endtask

  task automatic start_prog(input int max_instr);
    @(negedge clk); #1;
    expand(max_instr);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int i;
    i = 0;
    while (exp_q.size() > 0 && i < 5000) begin
      @(negedge clk); #1;
      i++;
    end
    chk({name, "_timeout"}, exp_q.size(), 0);
  endtask

  task automatic clear_rom(input logic [13:0] fill);
    for (int i = 0; i < 256; i++) imem[i] = fill;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      step_cnt <= step_cnt + int'(lfsr_step);
      we_cnt   <= we_cnt + int'(dmem_we);
      busy_cnt <= busy_cnt + int'(busy);
    end
  end

  // Single compare process: every cycle with an expected record is checked field by field.
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc", int'(imem_addr), e.pc);
        chk("load", int'(lfsr_load), e.load);
        if (e.load == 1) chk("seed", int'(lfsr_seed), e.seed);
        chk("step", int'(lfsr_step), e.step);
        chk("we", int'(dmem_we), e.we);
        chk("re", int'(dmem_re), e.re);
        chk("addr", int'(dmem_addr), e.addr);
        chk("tap", int'(tap), e.tap);
        chk("runs", int'(run_count), e.runs);
        chk("busy", int'(busy), e.busy);
        chk("halted", int'(halted), e.halted);
        chk("illegal", int'(illegal), e.ill);
      end else begin
        chk("quiet_strobes", int'({lfsr_load, lfsr_step, dmem_we, dmem_re}), 0);
      end
    end
  end

  initial begin
    #900000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int s0, b0, w0, len, kind, opc, imm;
    clear_rom(14'h3F00);
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_illegal", int'(illegal), 0);
    chk("rst_pc", int'(imem_addr), 0);
    chk("rst_tap", int'(tap), 0);
    chk("rst_addr", int'(dmem_addr), 0);
    chk("rst_runs", int'(run_count), 0);
    chk("rst_strobes", int'({lfsr_load, lfsr_step, dmem_we, dmem_re}), 0);
    chk("rst_seed", int'(lfsr_seed), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("idle_busy", int'(busy), 0);
    chk("idle_pc", int'(imem_addr), 0);

    // CFG_TAP 0x25, INIT_L 0xFF, HALT
    imem[0] = 14'h0125; imem[1] = 14'h02FF; imem[2] = 14'h3F00;
    start_prog(300);
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("t1_load", int'(lfsr_load), 1);
    chk("t1_seed", int'(lfsr_seed), 255);
    wait_done("t1");
    chk("t1_tap", int'(tap), 37);
    chk("t1_halted", int'(halted), 1);
    chk("t1_pc", int'(imem_addr), 2);

    // RUN_L 5, RUN_L 0, RUN_L 1, HALT
    clear_rom(14'h3F00);
    imem[0] = 14'h0305; imem[1] = 14'h0300; imem[2] = 14'h0301;
    s0 = step_cnt; b0 = busy_cnt;
    start_prog(300);
    wait_done("t2");
    chk("t2_steps", step_cnt - s0, 6);
    chk("t2_busy_cycles", busy_cnt - b0, 8);
    chk("t2_runs", int'(run_count), 3);
    chk("t2_pc", int'(imem_addr), 3);

    // INIT_ADDR 0xFE, ADD_ADDR 0x03, STORE, HALT
    clear_rom(14'h3F00);
    imem[0] = 14'h06FE; imem[1] = 14'h0703; imem[2] = 14'h0400;
    w0 = we_cnt;
    start_prog(300);
    wait_done("t3");
    chk("t3_addr", int'(dmem_addr), 1);
    chk("t3_we_pulses", we_cnt - w0, 1);

    // Illegal opcode 0x2A then HALT; restart from HALT
    clear_rom(14'h3F00);
    imem[0] = 14'h2A00;
    s0 = step_cnt; w0 = we_cnt;
    start_prog(300);
    wait_done("t4");
    chk("t4_illegal", int'(illegal), 1);
    chk("t4_halted", int'(halted), 1);
    chk("t4_no_strobes", (step_cnt - s0) + (we_cnt - w0), 0);
    start_prog(300);
    @(negedge clk); #1;
    chk("t4_restart_pc", int'(imem_addr), 0);
    chk("t4_restart_ill", int'(illegal), 0);
    chk("t4_restart_tap", int'(tap), 37);
    wait_done("t4b");

    // Random programs
    for (int p = 0; p < 25; p++) begin
      clear_rom(14'h3F00);
      len = $urandom_range(1, 12);
      for (int j = 0; j < len; j++) begin
        kind = $urandom_range(0, 8);
        imm  = $urandom_range(0, 255);
        if (kind <= 6) opc = kind + 1;
        else if (kind == 7) opc = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(8, 62);
        else opc = 1;
        if (opc == 3) imm = $urandom_range(0, 30);
        imem[j] = {opc[5:0], imm[7:0]};
      end
      start_prog(300);
      wait_done("rand");
    end

    // PC wrap: 256 no-ops, back to 0, then HALT patched in at address 1
    clear_rom(14'h0180);
    start_prog(257);
    push_halt(1);
    repeat (20) @(negedge clk);
    imem[1] = 14'h3F00;
    wait_done("wrap");
    chk("wrap_pc", int'(imem_addr), 1);

    // Reset during the third step of RUN_L 0x19
    clear_rom(14'h3F00);
    imem[0] = 14'h0319;
    start_prog(300);
    @(negedge clk); #1;
    @(negedge clk); #1;
    @(posedge clk); #1;
    chk("t5_step_before", int'(lfsr_step), 1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t5_step", int'(lfsr_step), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_pc", int'(imem_addr), 0);
    chk("t5_tap", int'(tap), 0);
    chk("t5_runs", int'(run_count), 0);
    m_tap = 0; m_addr = 0; m_runs = 0; m_ill = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    s0 = step_cnt;
    repeat (10) @(negedge clk);
    #1;
    chk("t5_no_steps", step_cnt - s0, 0);
    chk("t5_idle_busy", int'(busy), 0);

    // Restart after reset
    imem[0] = 14'h0303;
    start_prog(300);
    wait_done("t6");
    chk("t6_runs", int'(run_count), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
